servo_bank: RTL and testbench

//   N-channel arm servo PWM generator with per-channel slew-limited ramping and done reporting.

---
 rtl/servo_bank_pkg.sv | 14 +
 rtl/servo_bank_ch.sv | 118 +++++++++++
 rtl/servo_bank.sv | 78 +++++++
 tb/tb_servo_bank.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_bank_pkg.sv
// Shared types and constants for the servo PWM bank.
`timescale 1ns/1ps
package servo_bank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_HOLD = 2'd2
   } ch_state_e;

   localparam int STEP_W          = 4;
   localparam int DEF_START_RATIO = 5;

endpackage

// File: rtl/servo_bank_ch.sv
// One servo channel: enable/ramp/hold FSM, target latch, slew-limited ramp,
// period-aligned duty latch and PWM comparator.
`timescale 1ns/1ps
module servo_bank_ch
   import servo_bank_pkg::*;
#(
   parameter int RATIO_W     = 8,
   parameter int START_RATIO = DEF_START_RATIO
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic [RATIO_W-1:0] target,
   input  logic               target_update,
   input  logic [STEP_W-1:0]  step_size,
   input  logic               per_start,
   input  logic               step_ev,
   input  logic [RATIO_W-1:0] period_cnt,
   output logic               pwm_signal,
   output logic [RATIO_W-1:0] current,
   output logic               busy,
   output logic               done
);

   localparam logic [RATIO_W-1:0] START_VAL = RATIO_W'(START_RATIO);

   // Two guard bits keep the signed difference and the stepped value free of wrap.
   function automatic logic [RATIO_W-1:0] ramp_step(input logic [RATIO_W-1:0] cur,
                                                    input logic [RATIO_W-1:0] tgt,
                                                    input logic [STEP_W-1:0]  stp);
      logic [STEP_W-1:0]         stp_eff;
      logic signed [RATIO_W+1:0] s_cur;
      logic signed [RATIO_W+1:0] s_stp;
      logic signed [RATIO_W+1:0] diff;
      logic signed [RATIO_W+1:0] nxt;
      stp_eff = (stp == '0) ? STEP_W'(1) : stp;
      s_cur   = $signed({2'b00, cur});
      s_stp   = $signed({{(RATIO_W+2-STEP_W){1'b0}}, stp_eff});
      diff    = $signed({2'b00, tgt}) - s_cur;
      if (diff > s_stp)       nxt = s_cur + s_stp;
      else if (diff < -s_stp) nxt = s_cur - s_stp;
      else                    nxt = $signed({2'b00, tgt});
      return nxt[RATIO_W-1:0];
   endfunction

   ch_state_e          state_q, state_d;
   logic [RATIO_W-1:0] cur_q, cur_d;
   logic [RATIO_W-1:0] tgt_q, tgt_d;
   logic [RATIO_W-1:0] duty_q, duty_d;
   logic               en_q, en_d;
   logic               pwm_q, pwm_d;
   logic               done_q, done_d;

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      tgt_d   = target_update ? target : tgt_q;
      duty_d  = per_start ? cur_q : duty_q;
      en_d    = enable;
      done_d  = 1'b0;
      pwm_d   = enable && (state_q != ST_IDLE) && (period_cnt < duty_q);
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!en_q) begin
                  cur_d = START_VAL;
                  if (tgt_d == START_VAL) begin
                     state_d = ST_HOLD;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_RAMP;
                  end
               end
            end
            ST_RAMP: begin
               if (step_ev) cur_d = ramp_step(cur_q, tgt_q, step_size);
               // A coincident retarget takes priority and swallows the done pulse.
               if (cur_d == tgt_d) begin
                  state_d = ST_HOLD;
                  done_d  = !target_update;
               end
            end
            ST_HOLD: begin
               if (target_update && (target != tgt_q)) state_d = ST_RAMP;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cur_q   <= '0;
         tgt_q   <= '0;
         duty_q  <= '0;
         en_q    <= 1'b0;
         pwm_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         duty_q  <= duty_d;
         en_q    <= en_d;
         pwm_q   <= pwm_d;
         done_q  <= done_d;
      end
   end

   assign pwm_signal = pwm_q;
   assign current    = cur_q;
   assign busy       = (state_q == ST_RAMP);
   assign done       = done_q;

endmodule

// File: rtl/servo_bank.sv
// Parametrised servo PWM bank: shared prescaler, period counter and step timer
// driving NUM_CH independent ramping channels.
`timescale 1ns/1ps
module servo_bank
   import servo_bank_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int RATIO_W      = 8,
   parameter int PRESCALE     = 1024,
   parameter int STEP_PERIODS = 1,
   parameter int START_RATIO  = DEF_START_RATIO
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_CH-1:0]           enable,
   input  logic [NUM_CH*RATIO_W-1:0]   target,
   input  logic [NUM_CH-1:0]           target_update,
   input  logic [STEP_W-1:0]           step_size,
   output logic [NUM_CH-1:0]           pwm_signal,
   output logic [NUM_CH*RATIO_W-1:0]   current,
   output logic [NUM_CH-1:0]           busy,
   output logic [NUM_CH-1:0]           done
);

   localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam int SW = $clog2(STEP_PERIODS + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
   localparam logic [SW-1:0] STEP_MAX  = SW'(STEP_PERIODS - 1);

   logic [PW-1:0]      presc_q, presc_d;
   logic [RATIO_W-1:0] period_q, period_d;
   logic [SW-1:0]      step_cnt_q, step_cnt_d;
   logic               tick, per_start, step_ev;

   always_comb begin
      tick       = (presc_q == PRESC_MAX);
      per_start  = tick && (&period_q);
      step_ev    = per_start && (step_cnt_q == STEP_MAX);
      presc_d    = tick ? '0 : presc_q + PW'(1);
      period_d   = tick ? period_q + RATIO_W'(1) : period_q;
      step_cnt_d = step_cnt_q;
      if (per_start) step_cnt_d = step_ev ? '0 : step_cnt_q + SW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         presc_q    <= '0;
         period_q   <= '0;
         step_cnt_q <= '0;
      end else begin
         presc_q    <= presc_d;
         period_q   <= period_d;
         step_cnt_q <= step_cnt_d;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      servo_bank_ch #(
         .RATIO_W     (RATIO_W),
         .START_RATIO (START_RATIO)
      ) u_ch (
         .clock         (clock),
         .reset         (reset),
         .enable        (enable[i]),
         .target        (target[i*RATIO_W +: RATIO_W]),
         .target_update (target_update[i]),
         .step_size     (step_size),
         .per_start     (per_start),
         .step_ev       (step_ev),
         .period_cnt    (period_q),
         .pwm_signal    (pwm_signal[i]),
         .current       (current[i*RATIO_W +: RATIO_W]),
         .busy          (busy[i]),
         .done          (done[i])
      );
   end

endmodule

// File: tb/tb_servo_bank.sv
// Bench for servo_bank: behavioural reference model checked every cycle plus
// directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_servo_bank;

   localparam int NCH  = 4;
   localparam int RW   = 8;
   localparam int PS   = 4;
   localparam int SP   = 1;
   localparam int SR   = 5;
   localparam int PCNT = PS * (1 << RW);
   localparam int IDLE = 0, RAMP = 1, HOLD = 2;

   logic                clock = 1'b0;
   logic                reset;
   logic [NCH-1:0]      enable, target_update, pwm_signal, busy, done;
   logic [NCH*RW-1:0]   target, current;
   logic [3:0]          step_size;

   always #5 clock = ~clock;

   servo_bank #(
      .NUM_CH(NCH), .RATIO_W(RW), .PRESCALE(PS), .STEP_PERIODS(SP), .START_RATIO(SR)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .target(target),
      .target_update(target_update), .step_size(step_size), .pwm_signal(pwm_signal),
      .current(current), .busy(busy), .done(done)
   );

   int n_chk = 0, n_fail = 0;
   int m_cnt = 0, m_stepc = 0;
   int m_st[NCH], m_cur[NCH], m_tgt[NCH], m_duty[NCH];
   bit m_en[NCH], m_pwm[NCH], m_done[NCH];
   int done_cnt[NCH];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int cur_of(input int ch);
      return int'(current[ch*RW +: RW]);
   endfunction

   // Reference model: advances on every rising edge using the inputs seen there.
   initial begin : model
      forever begin : model_step
         bit ps, sev;
         int per, en, upd, trg, tn, cn, sn, dd, stp, d;
         @(posedge clock);
         if (reset) begin
            m_cnt = 0;
            m_stepc = 0;
            for (int i = 0; i < NCH; i++) begin
               m_st[i] = IDLE; m_cur[i] = 0; m_tgt[i] = 0; m_duty[i] = 0;
               m_en[i] = 0; m_pwm[i] = 0; m_done[i] = 0;
            end
         end else begin
            ps  = (m_cnt == PCNT - 1);
            per = m_cnt / PS;
            sev = 0;
            if (ps) begin
               if (m_stepc == SP - 1) begin sev = 1; m_stepc = 0; end
               else m_stepc++;
            end
            for (int i = 0; i < NCH; i++) begin
               en  = enable[i];
               upd = target_update[i];
               trg = int'(target[i*RW +: RW]);
               tn  = upd ? trg : m_tgt[i];
               cn  = m_cur[i];
               sn  = m_st[i];
               dd  = 0;
               m_pwm[i] = en && (m_st[i] != IDLE) && (per < m_duty[i]);
               if (ps) m_duty[i] = m_cur[i];
               if (!en) sn = IDLE;
               else if (m_st[i] == IDLE) begin
                  if (!m_en[i]) begin
                     cn = SR;
                     if (tn == SR) begin sn = HOLD; dd = 1; end
                     else sn = RAMP;
                  end
               end else if (m_st[i] == RAMP) begin
                  if (sev) begin
                     stp = (step_size == 0) ? 1 : int'(step_size);
                     d = m_tgt[i] - m_cur[i];
                     if (d > stp) cn = m_cur[i] + stp;
                     else if (d < -stp) cn = m_cur[i] - stp;
                     else cn = m_tgt[i];
                  end
                  if (cn == tn) begin sn = HOLD; dd = !upd; end
               end else begin
                  if (upd && trg != m_tgt[i]) sn = RAMP;
               end
               m_st[i] = sn; m_cur[i] = cn; m_tgt[i] = tn;
               m_en[i] = en; m_done[i] = dd;
            end
            m_cnt = (m_cnt + 1) % PCNT;
         end
      end
   end

   // Every-cycle comparison against the model, sampled on the falling edge.
   initial begin : compare
      forever begin : cmp_step
         logic [NCH-1:0]    e_pwm, e_busy, e_done;
         logic [NCH*RW-1:0] e_cur;
         @(negedge clock);
         for (int i = 0; i < NCH; i++) begin
            e_pwm[i]  = m_pwm[i];
            e_busy[i] = (m_st[i] == RAMP);
            e_done[i] = m_done[i];
            e_cur[i*RW +: RW] = RW'(m_cur[i]);
            if (done[i] === 1'b1) done_cnt[i]++;
         end
         chk("model_pwm", pwm_signal, e_pwm);
         chk("model_current", current, e_cur);
         chk("model_busy", busy, e_busy);
         chk("model_done", done, e_done);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic wait_count(input int val);
      int k;
      k = 0;
      do begin
         @(negedge clock);
         k++;
      end while (m_cnt != val && k < PCNT + 80);
      if (m_cnt != val) begin
         n_chk++;
         n_fail++;
         $display("FAIL period_wait: timed out after %0d cycles, wanted count %0d", k, val);
      end
   endtask

   task automatic wait_pstart();
      wait_count(0);
   endtask

   initial begin : stim
      int hi0, hi1;
      reset = 1'b1;
      enable = '0;
      target_update = '0;
      target = '0;
      step_size = 4'd5;
      cycles(3);
      reset = 1'b0;
      cycles(1);
      chk("reset_current", current, 0);
      chk("reset_busy", busy, 0);
      chk("reset_pwm", pwm_signal, 0);

      // ch0 ->20, ch1 ->0, ch3 ->40; update and enable in the same cycle
      target = {8'd40, 8'd0, 8'd0, 8'd20};
      target_update = 4'b1011;
      enable = 4'b1011;
      cycles(1);
      target_update = '0;
      chk("start_cur0", cur_of(0), 5);
      chk("start_cur1", cur_of(1), 5);
      chk("start_busy", busy, 4'b1011);
      wait_pstart();
      chk("ramp1_cur0", cur_of(0), 10);
      chk("ramp1_cur1", cur_of(1), 0);
      chk("ramp1_cur3", cur_of(3), 10);
      wait_pstart();
      chk("ramp2_cur0", cur_of(0), 15);
      chk("ramp2_cur3", cur_of(3), 15);
      target[31:24] = 8'd10;
      target_update = 4'b1000;
      cycles(1);
      target_update = '0;
      chk("retarget_busy3", busy[3], 1);
      wait_pstart();
      chk("ramp3_cur0", cur_of(0), 20);
      chk("retarget_cur3", cur_of(3), 10);
      cycles(2);
      chk("done_cnt0", done_cnt[0], 1);
      chk("done_cnt1", done_cnt[1], 1);
      chk("done_cnt3", done_cnt[3], 1);
      chk("hold_busy", busy, 0);

      // ch0 to duty 64 with step 15, then measure one full PWM period
      step_size = 4'd15;
      target[7:0] = 8'd64;
      target_update = 4'b0001;
      cycles(1);
      target_update = '0;
      wait_pstart();
      chk("b_cur0_a", cur_of(0), 35);
      wait_pstart();
      chk("b_cur0_b", cur_of(0), 50);
      wait_pstart();
      chk("b_cur0_c", cur_of(0), 64);
      wait_pstart();
      hi0 = 0;
      hi1 = 0;
      for (int j = 0; j < PCNT; j++) begin
         hi0 += int'(pwm_signal[0]);
         hi1 += int'(pwm_signal[1]);
         @(negedge clock);
      end
      chk("pwm_high_duty64", hi0, 64 * PS);
      chk("pwm_high_duty0", hi1, 0);
      chk("done_cnt0_b", done_cnt[0], 2);

      // ch2: drop enable mid-ramp, then re-enable
      target[23:16] = 8'd200;
      target_update = 4'b0100;
      enable[2] = 1'b1;
      cycles(1);
      target_update = '0;
      wait_pstart();
      chk("c_cur2", cur_of(2), 20);
      cycles(1);
      chk("c_pwm2_high", pwm_signal[2], 1);
      enable[2] = 1'b0;
      cycles(2);
      chk("c_pwm2_low", pwm_signal[2], 0);
      chk("c_busy2", busy[2], 0);
      chk("c_cur2_held", cur_of(2), 20);
      enable[2] = 1'b1;
      cycles(1);
      chk("c_cur2_restart", cur_of(2), 5);
      chk("c_busy2_again", busy[2], 1);
      chk("c_done_cnt2", done_cnt[2], 0);

      // ch1 retargeted on the very step that reaches its target; ch2 keeps ramping
      target[15:8] = 8'd30;
      target_update = 4'b0010;
      cycles(1);
      target_update = '0;
      wait_pstart();
      chk("d_cur1", cur_of(1), 15);
      chk("d_cur2", cur_of(2), 20);
      wait_count(PCNT - 1);
      target[15:8] = 8'd60;
      target_update = 4'b0010;
      cycles(1);
      target_update = '0;
      chk("d_cur1_reach", cur_of(1), 30);
      chk("d_busy1", busy[1], 1);
      chk("d_cur2_b", cur_of(2), 35);
      cycles(2);
      chk("d_done_cnt1", done_cnt[1], 1);
      chk("d_done_cnt2", done_cnt[2], 0);

      // all channels ramping, then reset
      target = {4{8'd250}};
      target_update = 4'b1111;
      cycles(1);
      target_update = '0;
      chk("e_busy_all", busy, 4'b1111);
      cycles(7);
      reset = 1'b1;
      cycles(1);
      chk("e_reset_current", current, 0);
      chk("e_reset_busy", busy, 0);
      chk("e_reset_pwm", pwm_signal, 0);
      chk("e_reset_done", done, 0);
      reset = 1'b0;
      cycles(1);
      chk("e_restart_cur", current, {4{8'd5}});
      wait_pstart();
      chk("e_first_step_cur", current, 0);
      cycles(3);
      chk("e_final_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
